int_mac_tree: RTL and testbench
===============================

# int_mac_tree

Parametrised streaming integer dot-product engine, successor to the fixed 8-lane fp32 MAC tree. Each accepted beat multiplies `LANES` signed operand pairs, reduces the products through a registered adder tree, and accumulates the tree sum across beats until a beat flagged `in_last`. The vector result is then presented on a valid/ready output together with its beat count. The block sits between the operand-fetch stream and the vector-ALU result writeback.

## Interface
- `LANES`, default 8: lanes per beat; power of two, ≥2. `P = log2(LANES)`.
- `DATA_W`, default 16: signed operand width per lane.
- `ACC_W`, default 48: signed accumulator and result width; must be ≥ `2*DATA_W+P`.

- `clk`  in  1  clock; all state updates on the rising edge.
- `rst`  in  1  asynchronous, active-low reset.
- `in_valid`  in  1  operand beat valid.
- `in_ready`  out  1  beat accepted when `in_valid && in_ready`.
- `in_last`  in  1  final beat of the current vector.
- `a`  in  `LANES*DATA_W`  lane i is at bits `[i*DATA_W +: DATA_W]`, signed.
- `b`  in  `LANES*DATA_W`  same packing as `a`.
- `out_valid`  out  1  result held.
- `out_ready`  in  1  result consumed when `out_valid && out_ready`.
- `out_data`  out  `ACC_W`  signed vector sum.
- `out_beats`  out  16  beats in the vector; saturates at 65535.
- `out_ovf`  out  1  overflow occurred in the vector (SAT build only; 0 otherwise).

## Operation
- Pipeline: multiply stage (1 reg) → P tree levels (1 reg each) → accumulate/output stage. Each stage carries its own `valid` and `last` bits.
- Product width is `2*DATA_W`. Each tree level sign-extends by 1 bit. Final tree width is `2*DATA_W+P`, sign-extended to `ACC_W`.
- Global enable: `en = !(out_valid && !out_ready)`. `in_ready = en`; this is a combinational path from `out_ready`. When `en` is 0, every stage holds.
- Bubbles (`in_valid=0`) propagate as invalid stages. Invalid stages never touch `acc` or the beat counter.
- Accumulate stage, valid and not last: `acc <= acc + tree`, `beats <= beats+1` (saturating).
- Accumulate stage, valid and last:
  - `out_data <= acc + tree`, `out_beats <= beats+1`, `out_ovf <= ovf`, `out_valid <= 1`.
  - Then `acc`, `beats` and `ovf` are cleared, so the next vector starts from 0.
- Without a last beat, `out_valid` clears on `out_valid && out_ready`.
- Simultaneous output handshake and new last beat: the output register reloads in the same cycle, `out_valid` stays 1, and there is no stall.
- Reset (any time, including mid-vector):
  - All stage valid bits, `acc`, `beats` and `ovf` go to 0.
  - `out_valid=0`, `out_data=0`, `out_beats=0`, `out_ovf=0`, `in_ready=1`.
  - Any partial vector is discarded.

## Timing
- Latency: a last beat accepted at edge E produces `out_valid=1` after edge E+P+2. For LANES=8 that is 5 cycles.
- Throughput is 1 beat/cycle while `out_ready` is high or `out_valid` is low.
- A single stalled result freezes the whole pipeline. No beat is dropped or reordered.
- `out_data`, `out_beats` and `out_ovf` are stable while `out_valid && !out_ready`.

## Configuration
- `INT_MAC_TREE_SAT_EN` defined:
  - Accumulator adds saturate to the signed `ACC_W` limits.
  - Any saturating add sets a sticky `ovf` for the vector, reported on `out_ovf`.
- `INT_MAC_TREE_SAT_EN` undefined:
  - Two's-complement wrap.
  - `out_ovf` is tied to 0.

## Test plan
Defaults: LANES=8, DATA_W=16, ACC_W=48, unless noted.
1. Single-beat vector: all `a`=2, all `b`=3, `in_last`=1, `out_ready`=1 → `out_data`=48 and `out_beats`=1, with `out_valid` rising 5 cycles after accept.
2. Two back-to-back vectors: 4 beats with `a` lane i = i and `b`=1 each beat, then a 1-beat vector with all `a`=1, `b`=1 → results 112/4 then 8/1, showing `acc` cleared between vectors.
3. Signed extremes: all `a`=-32768, all `b`=32767, 1 beat → `out_data`=-8589672448.
4. Backpressure: hold `out_ready`=0 for 10 cycles while a second vector streams → `in_ready` low exactly while `out_valid && !out_ready`; both results arrive in order and correct.
5. Reset mid-vector: pull `rst` low after 2 beats of a 4-beat vector → all outputs 0 immediately; a following 1-beat vector of all 1s yields 8.
6. Overflow, ACC_W=35: 2 beats of `a`=`b`=-32768 → with SAT, `out_data`=17179869183 and `out_ovf`=1; without SAT, `out_data`=-17179869184 and `out_ovf`=0.

Source files
------------

// File: rtl/int_mac_tree.sv
// int_mac_tree: streaming signed dot-product engine (operand reg, multiply reg, P-level adder tree, accumulator).
// Build option: define INT_MAC_TREE_SAT_EN for saturating accumulation with a sticky per-vector out_ovf.
module int_mac_tree #(
  parameter int LANES  = 8,
  parameter int DATA_W = 16,
  parameter int ACC_W  = 48
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      in_valid,
  output logic                      in_ready,
  input  logic                      in_last,
  input  logic [LANES*DATA_W-1:0]   a,
  input  logic [LANES*DATA_W-1:0]   b,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic [ACC_W-1:0]          out_data,
  output logic [15:0]               out_beats,
  output logic                      out_ovf
);

  localparam int P  = $clog2(LANES);
  localparam int PW = 2 * DATA_W;

  // Handshake: a beat moves on in_valid && in_ready; a result leaves on out_valid && out_ready.
  // in_ready is combinational on out_ready; every stage freezes only while a result is stuck.
  logic w_en;
  logic r_out_valid;
  assign w_en     = !(r_out_valid && !out_ready);
  assign in_ready = w_en;

  // Stage flags: [0] operand reg, [1] multiply reg, [l+1] tree level l.
  logic [P+1:0] r_v;
  logic [P+1:0] r_l;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_v <= '0;
      r_l <= '0;
    end else if (w_en) begin
      r_v <= {r_v[P:0], in_valid};
      r_l <= {r_l[P:0], in_last};
    end
  end

  logic signed [DATA_W-1:0] r_a    [LANES];
  logic signed [DATA_W-1:0] r_b    [LANES];
  logic signed [PW-1:0]     r_prod [LANES];

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < LANES; i++) begin
        r_a[i]    <= '0;
        r_b[i]    <= '0;
        r_prod[i] <= '0;
      end
    end else if (w_en) begin
      for (int i = 0; i < LANES; i++) begin
        r_a[i]    <= a[i*DATA_W +: DATA_W];
        r_b[i]    <= b[i*DATA_W +: DATA_W];
        r_prod[i] <= PW'(r_a[i]) * PW'(r_b[i]);
      end
    end
  end

  // Each tree level halves the node count and grows one bit, so no level can overflow.
  for (genvar l = 1; l <= P; l++) begin : g_lvl
    localparam int LW = PW + l;
    localparam int N  = LANES >> l;
    logic signed [LW-2:0] w_in  [2*N];
    logic signed [LW-1:0] r_sum [N];

    if (l == 1) begin : g_src
      for (genvar j = 0; j < 2*N; j++) begin : g_j
        assign w_in[j] = r_prod[j];
      end
    end else begin : g_src
      for (genvar j = 0; j < 2*N; j++) begin : g_j
        assign w_in[j] = g_lvl[l-1].r_sum[j];
      end
    end

    always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
        for (int j = 0; j < N; j++) r_sum[j] <= '0;
      end else if (w_en) begin
        for (int j = 0; j < N; j++) r_sum[j] <= LW'(w_in[2*j]) + LW'(w_in[2*j+1]);
      end
    end
  end

  logic signed [ACC_W-1:0] w_tree;
  logic signed [ACC_W-1:0] w_acc_next;
  logic signed [ACC_W-1:0] r_acc;
  logic signed [ACC_W-1:0] r_out_data;
  logic [15:0]             r_beats;
  logic [15:0]             w_beats_inc;
  logic [15:0]             r_out_beats;

  assign w_tree      = ACC_W'(g_lvl[P].r_sum[0]);
  assign w_beats_inc = (r_beats == 16'hFFFF) ? r_beats : r_beats + 16'd1;

`ifdef INT_MAC_TREE_SAT_EN
  logic signed [ACC_W:0] w_wide;
  logic                  w_add_ovf;
  logic                  r_ovf;
  logic                  r_out_ovf;

  // One guard bit: the two top bits disagree exactly when the ACC_W-bit sum overflowed.
  assign w_wide    = {r_acc[ACC_W-1], r_acc} + {w_tree[ACC_W-1], w_tree};
  assign w_add_ovf = w_wide[ACC_W] ^ w_wide[ACC_W-1];

  always_comb begin
    w_acc_next = w_wide[ACC_W-1:0];
    if (w_add_ovf) begin
      w_acc_next = w_wide[ACC_W] ? {1'b1, {(ACC_W-1){1'b0}}} : {1'b0, {(ACC_W-1){1'b1}}};
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_ovf     <= 1'b0;
      r_out_ovf <= 1'b0;
    end else if (w_en && r_v[P+1]) begin
      if (r_l[P+1]) begin
        r_out_ovf <= r_ovf | w_add_ovf;
        r_ovf     <= 1'b0;
      end else begin
        r_ovf     <= r_ovf | w_add_ovf;
      end
    end
  end

  assign out_ovf = r_out_ovf;
`else
  assign w_acc_next = r_acc + w_tree;
  assign out_ovf    = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_acc       <= '0;
      r_beats     <= '0;
      r_out_data  <= '0;
      r_out_beats <= '0;
      r_out_valid <= 1'b0;
    end else if (w_en) begin
      if (r_v[P+1]) begin
        if (r_l[P+1]) begin
          r_out_data  <= w_acc_next;
          r_out_beats <= w_beats_inc;
          r_acc       <= '0;
          r_beats     <= '0;
        end else begin
          r_acc       <= w_acc_next;
          r_beats     <= w_beats_inc;
        end
      end
      // w_en while a result is held means out_ready is high, so the result is consumed.
      if (r_v[P+1] && r_l[P+1]) begin
        r_out_valid <= 1'b1;
      end else if (r_out_valid) begin
        r_out_valid <= 1'b0;
      end
    end
  end

  assign out_valid = r_out_valid;
  assign out_data  = r_out_data;
  assign out_beats = r_out_beats;

endmodule

// File: tb/tb_int_mac_tree.sv
// Bench for int_mac_tree: directed cases plus random vectors against a dot-product reference model.
module tb_int_mac_tree;
  localparam int LANES = 8;
  localparam int DW    = 16;
  localparam int AW    = 48;
  localparam int AW2   = 35;
  localparam int VW    = LANES * DW;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  logic          in_valid, in_ready, in_last, out_valid, out_ready, out_ovf;
  logic [VW-1:0] a, b;
  logic [AW-1:0] out_data;
  logic [15:0]   out_beats;

  logic           in2_valid, in2_ready, in2_last, out2_valid, out2_ready, out2_ovf;
  logic [VW-1:0]  a2, b2;
  logic [AW2-1:0] out2_data;
  logic [15:0]    out2_beats;

  int_mac_tree #(.LANES(LANES), .DATA_W(DW), .ACC_W(AW)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .in_last(in_last),
    .a(a), .b(b), .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .out_beats(out_beats), .out_ovf(out_ovf)
  );

  int_mac_tree #(.LANES(LANES), .DATA_W(DW), .ACC_W(AW2)) dut35 (
    .clk(clk), .rst(rst), .in_valid(in2_valid), .in_ready(in2_ready), .in_last(in2_last),
    .a(a2), .b(b2), .out_valid(out2_valid), .out_ready(out2_ready), .out_data(out2_data),
    .out_beats(out2_beats), .out_ovf(out2_ovf)
  );

  // ---------------- checking ----------------
  int errors = 0;
  int checks = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", tag, $signed(got), got, $signed(exp), exp);
    end
  endtask

  // ---------------- reference model ----------------
  function automatic longint model_add(input longint acc, input longint t, input int aw, output bit ovf);
    longint s;
    longint mx;
    longint mn;
    s   = acc + t;
    mx  = (longint'(1) <<< (aw - 1)) - 1;
    mn  = -(longint'(1) <<< (aw - 1));
    ovf = 1'b0;
`ifdef INT_MAC_TREE_SAT_EN
    if (s > mx) begin s = mx; ovf = 1'b1; end
    else if (s < mn) begin s = mn; ovf = 1'b1; end
`else
    if (s > mx || s < mn) s = (s <<< (64 - aw)) >>> (64 - aw);
`endif
    return s;
  endfunction

  function automatic longint dot(input logic [VW-1:0] va, input logic [VW-1:0] vb);
    longint sum;
    logic signed [DW-1:0] xa;
    logic signed [DW-1:0] xb;
    sum = 0;
    for (int i = 0; i < LANES; i++) begin
      xa  = va[i*DW +: DW];
      xb  = vb[i*DW +: DW];
      sum = sum + longint'(xa) * longint'(xb);
    end
    return sum;
  endfunction

  function automatic logic [VW-1:0] fill(input int v);
    logic [VW-1:0] r;
    for (int i = 0; i < LANES; i++) r[i*DW +: DW] = DW'(v);
    return r;
  endfunction

  function automatic logic [VW-1:0] ramp();
    logic [VW-1:0] r;
    for (int i = 0; i < LANES; i++) r[i*DW +: DW] = DW'(i);
    return r;
  endfunction

  // ---------------- scoreboard ----------------
  logic [63:0] exp_q[$];
  logic [15:0] exp_beats_q[$];
  logic        exp_ovf_q[$];
  longint      m_acc = 0;
  int          m_beats = 0;
  bit          m_ovf = 1'b0;
  bit          m_o;
  longint      last_data = 0;
  logic [15:0] last_beats = '0;
  logic [63:0] e_data;

  always @(negedge clk) begin
    if (!rst) begin
      m_acc = 0; m_beats = 0; m_ovf = 1'b0;
      exp_q.delete(); exp_beats_q.delete(); exp_ovf_q.delete();
    end else begin
      check("in_ready", 64'(in_ready), 64'(!(out_valid && !out_ready)));
      if (in_valid && in_ready) begin
        m_acc = model_add(m_acc, dot(a, b), AW, m_o);
        m_ovf = m_ovf | m_o;
        if (m_beats < 65535) m_beats++;
        if (in_last) begin
          exp_q.push_back(64'(m_acc));
          exp_beats_q.push_back(16'(m_beats));
          exp_ovf_q.push_back(m_ovf);
          m_acc = 0; m_beats = 0; m_ovf = 1'b0;
        end
      end
      if (out_valid && out_ready) begin
        check("result_pending", 64'(out_valid), 64'(exp_q.size() > 0));
        if (exp_q.size() > 0) begin
          e_data = exp_q.pop_front();
          check("out_data", 64'(longint'($signed(out_data))), e_data);
          check("out_beats", 64'(out_beats), 64'(exp_beats_q.pop_front()));
          check("out_ovf", 64'(out_ovf), 64'(exp_ovf_q.pop_front()));
        end
        last_data  = longint'($signed(out_data));
        last_beats = out_beats;
      end
    end
  end

  bit rand_rdy = 1'b0;
  always @(posedge clk) begin
    #1;
    if (rand_rdy) out_ready = ($urandom_range(0, 99) < 70);
  end

  // ---------------- driver tasks ----------------
  task automatic send_beat(input logic [VW-1:0] va, input logic [VW-1:0] vb, input logic last);
    bit acc;
    int n;
    a = va; b = vb; in_last = last; in_valid = 1'b1;
    n = 0;
    acc = 1'b0;
    while (!acc && n < 200) begin
      @(negedge clk);
      acc = in_ready;
      @(posedge clk);
      #1;
      n++;
    end
    check("accept_in_budget", 64'(acc), 64'(1));
    in_valid = 1'b0;
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (exp_q.size() > 0 && n < 1000) begin
      @(posedge clk);
      n++;
    end
    #1;
    check("drain", 64'(exp_q.size()), 64'(0));
  endtask

  // ---------------- main sequence ----------------
  initial begin
    logic [VW-1:0] va, vb;
    int nb, n;
    in_valid = 1'b0; in_last = 1'b0; a = '0; b = '0; out_ready = 1'b1;
    in2_valid = 1'b0; in2_last = 1'b0; a2 = '0; b2 = '0; out2_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check("rst_out_valid", 64'(out_valid), 64'(0));
    check("rst_out_data", 64'(out_data), 64'(0));
    check("rst_out_beats", 64'(out_beats), 64'(0));
    check("rst_out_ovf", 64'(out_ovf), 64'(0));
    check("rst_in_ready", 64'(in_ready), 64'(1));
    check("rst_out2_valid", 64'(out2_valid), 64'(0));
    rst = 1'b1;
    @(posedge clk);
    #1;

    // Single beat: 8 * 2 * 3 = 48, valid 5 edges after the accepting edge.
    a = fill(2); b = fill(3); in_last = 1'b1; in_valid = 1'b1;
    @(negedge clk);
    check("t1_accept", 64'(in_ready), 64'(1));
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    for (int k = 1; k <= 6; k++) begin
      @(negedge clk);
      check((k < 6) ? "t1_not_yet" : "t1_valid_lat5", 64'(out_valid), 64'(k == 6));
    end
    check("t1_data", 64'(out_data), 64'(48));
    check("t1_beats", 64'(out_beats), 64'(1));
    drain();

    // Back-to-back vectors: 4 * (0+..+7) = 112 over 4 beats, then 8 over 1 beat.
    for (int bt = 0; bt < 4; bt++) send_beat(ramp(), fill(1), bt == 3);
    send_beat(fill(1), fill(1), 1'b1);
    drain();
    check("t2_second_data", 64'(last_data), 64'(8));
    check("t2_second_beats", 64'(last_beats), 64'(1));

    send_beat(ramp(), fill(1), 1'b0);
    send_beat(ramp(), fill(1), 1'b1);
    drain();
    check("t2_two_beat", 64'(last_data), 64'(56));

    // Signed extremes.
    send_beat(fill(-32768), fill(32767), 1'b1);
    drain();
    check("t3_extreme", 64'(last_data), 64'(-64'sd8589672448));

    // Backpressure: result held for several cycles while a long vector streams in.
    out_ready = 1'b0;
    send_beat(fill(1), fill(5), 1'b1);
    fork
      begin
        repeat (14) @(posedge clk);
        #1;
        out_ready = 1'b1;
      end
    join_none
    for (int bt = 0; bt < 10; bt++) send_beat(fill(bt - 3), ramp(), bt == 9);
    drain();
    check("t4_second", 64'(last_data), 64'(28 * (-30 + 45)));
    check("t4_second_beats", 64'(last_beats), 64'(10));

    // Reset mid-vector with a result held.
    out_ready = 1'b0;
    send_beat(fill(3), fill(3), 1'b1);
    send_beat(fill(7), fill(7), 1'b0);
    send_beat(fill(7), fill(7), 1'b0);
    n = 0;
    while (!out_valid && n < 20) begin
      @(negedge clk);
      n++;
    end
    check("t5_held", 64'(out_valid), 64'(1));
    rst = 1'b0;
    #1;
    check("t5_rst_valid", 64'(out_valid), 64'(0));
    check("t5_rst_data", 64'(out_data), 64'(0));
    check("t5_rst_beats", 64'(out_beats), 64'(0));
    check("t5_rst_in_ready", 64'(in_ready), 64'(1));
    @(posedge clk);
    #1;
    rst = 1'b1; out_ready = 1'b1;
    send_beat(fill(1), fill(1), 1'b1);
    drain();
    check("t5_after_data", 64'(last_data), 64'(8));
    check("t5_after_beats", 64'(last_beats), 64'(1));

    // Overflow on the 35-bit accumulator: 2 beats of 8 * 2^30.
    a2 = fill(-32768); b2 = fill(-32768); in2_valid = 1'b1; in2_last = 1'b0;
    @(posedge clk);
    #1;
    in2_last = 1'b1;
    @(posedge clk);
    #1;
    in2_valid = 1'b0; in2_last = 1'b0;
    n = 0;
    while (!out2_valid && n < 20) begin
      @(negedge clk);
      n++;
    end
    check("t6_valid", 64'(out2_valid), 64'(1));
    check("t6_beats", 64'(out2_beats), 64'(2));
`ifdef INT_MAC_TREE_SAT_EN
    check("t6_data", 64'(longint'($signed(out2_data))), 64'(64'sd17179869183));
    check("t6_ovf", 64'(out2_ovf), 64'(1));
`else
    check("t6_data", 64'(longint'($signed(out2_data))), 64'(-64'sd17179869184));
    check("t6_ovf", 64'(out2_ovf), 64'(0));
`endif

    // Random vectors with bubbles and random out_ready.
    rand_rdy = 1'b1;
    for (int v = 0; v < 40; v++) begin
      nb = $urandom_range(1, 6);
      for (int bt = 0; bt < nb; bt++) begin
        for (int i = 0; i < LANES; i++) begin
          va[i*DW +: DW] = ($urandom_range(0, 9) == 0) ? 16'h8000 : 16'($urandom);
          vb[i*DW +: DW] = ($urandom_range(0, 9) == 0) ? 16'h7FFF : 16'($urandom);
        end
        send_beat(va, vb, bt == nb - 1);
        if ($urandom_range(0, 3) == 0) begin
          @(posedge clk);
          #1;
        end
      end
    end
    drain();
    rand_rdy = 1'b0;
    out_ready = 1'b1;

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
